// File: rtl/mem_stage.sv
// Memory stage: issues loads/stores to a word-addressed data memory and formats results for writeback.
// Optional MISALIGN_TRAP_EN turns misaligned half/word accesses into non-writing wb entries flagged by misalign.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_rd_we,
    output logic [29:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic        dmem_wen,
    output logic        dmem_ren,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic        wb_we,
    output logic [31:0] wb_data
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    typedef enum logic [0:0] {IDLE, LOAD_WAIT} state_t;

    state_t      state_q, state_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [2:0]  ld_funct3_q, ld_funct3_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic        ld_we_q, ld_we_d;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_q, misalign_d;
`endif

    logic        accept;
    logic        is_load;
    logic        is_store;
    logic        misaligned;
    logic [1:0]  acc_size;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;

    assign ex_ready = !rst && (state_q == IDLE) && (!wb_valid_q || wb_ready);
    assign accept   = ex_valid && ex_ready;
    assign is_load  = ex_load;
    assign is_store = ex_store && !ex_load;

    // Access size: 0 = byte, 1 = half, 2 = word (reserved codes behave as word).
    always_comb begin
        acc_size = 2'd2;
        case (ex_funct3)
            3'b000, 3'b100: acc_size = 2'd0;
            3'b001, 3'b101: acc_size = 2'd1;
            default:        acc_size = 2'd2;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign misaligned = (is_load || is_store) &&
                        (((acc_size == 2'd1) && ex_result[0]) ||
                         ((acc_size == 2'd2) && (ex_result[1:0] != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    assign dmem_addr = ex_result[31:2];
    assign dmem_wen  = accept && is_store && !misaligned;
    assign dmem_ren  = accept && is_load && !misaligned;

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = ex_store_data;
        case (acc_size)
            2'd0: begin
                dmem_be    = 4'b0001 << ex_result[1:0];
                dmem_wdata = {4{ex_store_data[7:0]}};
            end
            2'd1: begin
                dmem_be    = 4'b0011 << {ex_result[1], 1'b0};
                dmem_wdata = {2{ex_store_data[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = ex_store_data;
            end
        endcase
    end

    always_comb begin
        ld_byte = dmem_rdata[7:0];
        case (ld_off_q)
            2'd0: ld_byte = dmem_rdata[7:0];
            2'd1: ld_byte = dmem_rdata[15:8];
            2'd2: ld_byte = dmem_rdata[23:16];
            2'd3: ld_byte = dmem_rdata[31:24];
            default: ld_byte = dmem_rdata[7:0];
        endcase
        ld_half = ld_off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (ld_funct3_q)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_data = {24'd0, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_data = {16'd0, ld_half};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wb_valid_d  = wb_valid_q;
        wb_we_d     = wb_we_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        ld_funct3_d = ld_funct3_q;
        ld_off_d    = ld_off_q;
        ld_rd_d     = ld_rd_q;
        ld_we_d     = ld_we_q;
`ifdef MISALIGN_TRAP_EN
        misalign_d  = misalign_q;
`endif
        if (state_q == LOAD_WAIT) begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wb_data_d  = load_data;
            wb_rd_d    = ld_rd_q;
            wb_we_d    = ld_we_q;
        end else begin
            // A drain clears the slot; an accepted result below overwrites it on the same edge.
            if (wb_valid_q && wb_ready) begin
                wb_valid_d = 1'b0;
            end
            if (accept) begin
`ifdef MISALIGN_TRAP_EN
                misalign_d = misaligned;
`endif
                if (misaligned) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = ex_result;
                    wb_rd_d    = ex_rd;
                    wb_we_d    = 1'b0;
                end else if (is_load) begin
                    state_d     = LOAD_WAIT;
                    ld_funct3_d = ex_funct3;
                    ld_off_d    = ex_result[1:0];
                    ld_rd_d     = ex_rd;
                    ld_we_d     = ex_rd_we && (ex_rd != 5'd0);
                end else if (!is_store) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = ex_result;
                    wb_rd_d    = ex_rd;
                    wb_we_d    = ex_rd_we && (ex_rd != 5'd0);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            ld_funct3_q <= 3'd0;
            ld_off_q    <= 2'd0;
            ld_rd_q     <= 5'd0;
            ld_we_q     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            ld_funct3_q <= ld_funct3_d;
            ld_off_q    <= ld_off_d;
            ld_rd_q     <= ld_rd_d;
            ld_we_q     <= ld_we_d;
`ifdef MISALIGN_TRAP_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_we    = wb_we_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign = misalign_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of expected wb entries plus per-scenario inline checks.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_load;
    logic        ex_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;
    logic [29:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_wen;
    logic        dmem_ren;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [31:0] wb_data;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
        logic        mis;
        logic        chk_data;
    } exp_t;

    exp_t sb_q[$];

    mem_stage dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_load(ex_load), .ex_store(ex_store),
        .ex_funct3(ex_funct3), .ex_result(ex_result), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_wen(dmem_wen), .dmem_ren(dmem_ren), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data)
`ifdef MISALIGN_TRAP_EN
        , .misalign(misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every wb handshake is matched against the oldest expected entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && wb_valid === 1'b1 && wb_ready === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL wb_unexpected got rd=%0d we=%b data=%h want no entry", wb_rd, wb_we, wb_data);
            end else begin
                e = sb_q.pop_front();
                if (wb_rd !== e.rd || wb_we !== e.we || (e.chk_data && wb_data !== e.data)) begin
                    bad++;
                    $display("[TB] FAIL wb_entry got rd=%0d we=%b data=%h want rd=%0d we=%b data=%h",
                             wb_rd, wb_we, wb_data, e.rd, e.we, e.data);
                end
`ifdef MISALIGN_TRAP_EN
                total++;
                if (misalign !== e.mis) begin
                    bad++;
                    $display("[TB] FAIL wb_misalign got=%b want=%b", misalign, e.mis);
                end
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] res,
                          input logic [31:0] sd, input logic [4:0] rd, input logic we);
        ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
        ex_result = res; ex_store_data = sd; ex_rd = rd; ex_rd_we = we;
    endtask

    task automatic idle_in();
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0, 5'd3, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (ex_ready !== 1'b0 || dmem_ren !== 1'b0 || dmem_wen !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_handshake got ready=%b ren=%b wen=%b want 0 0 0", ex_ready, dmem_ren, dmem_wen);
        end
        total++;
        if (wb_valid !== 1'b0 || wb_we !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_wb got valid=%b we=%b rd=%0d data=%h want all zero", wb_valid, wb_we, wb_rd, wb_data);
        end
`ifdef MISALIGN_TRAP_EN
        total++;
        if (misalign !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_misalign got=%b want=0", misalign);
        end
`endif
        idle_in();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic do_alu(input logic [31:0] res, input logic [4:0] rd, input logic we);
        set_op(1'b0, 1'b0, 3'b000, res, 32'd0, rd, we);
        @(negedge clk);
        total++;
        if (ex_ready !== 1'b1 || dmem_ren !== 1'b0 || dmem_wen !== 1'b0) begin
            bad++;
            $display("[TB] FAIL alu_issue got ready=%b ren=%b wen=%b want 1 0 0", ex_ready, dmem_ren, dmem_wen);
        end
        sb_q.push_back({rd, we && (rd != 5'd0), res, 1'b0, 1'b1});
        tick();
        idle_in();
        @(negedge clk);
        total++;
        if (wb_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL alu_latency got wb_valid=%b want=1", wb_valid);
        end
        tick();
    endtask

    task automatic test_alu();
        do_alu(32'h0000_0010, 5'd5, 1'b1);
        do_alu(32'hDEAD_BEEF, 5'd0, 1'b1);
        do_alu(32'h0000_1234, 5'd31, 1'b0);
    endtask

    task automatic do_load(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] expd, input logic [4:0] rd);
        set_op(1'b1, st, f3, addr, 32'hFFFF_FFFF, rd, 1'b1);
        dmem_rdata = rdata;
        @(negedge clk);
        total++;
        if (ex_ready !== 1'b1 || dmem_ren !== 1'b1 || dmem_wen !== 1'b0 || dmem_addr !== addr[31:2]) begin
            bad++;
            $display("[TB] FAIL load_issue got ready=%b ren=%b wen=%b addr=%h want 1 1 0 %h",
                     ex_ready, dmem_ren, dmem_wen, dmem_addr, addr[31:2]);
        end
        sb_q.push_back({rd, rd != 5'd0, expd, 1'b0, 1'b1});
        tick();
        idle_in();
        @(negedge clk);
        total++;
        if (ex_ready !== 1'b0 || dmem_ren !== 1'b0 || wb_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL load_wait got ready=%b ren=%b wb_valid=%b want 0 0 0", ex_ready, dmem_ren, wb_valid);
        end
        tick();
        @(negedge clk);
        total++;
        if (wb_valid !== 1'b1 || wb_data !== expd) begin
            bad++;
            $display("[TB] FAIL load_result got valid=%b data=%h want 1 %h", wb_valid, wb_data, expd);
        end
        tick();
    endtask

    task automatic test_load();
        do_load(1'b0, 3'b000, 32'h0000_0003, 32'h8011_2233, 32'hFFFF_FF80, 5'd1);
        do_load(1'b0, 3'b100, 32'h0000_0003, 32'h8011_2233, 32'h0000_0080, 5'd2);
        do_load(1'b0, 3'b000, 32'h0000_0101, 32'h0000_7F00, 32'h0000_007F, 5'd3);
        do_load(1'b0, 3'b001, 32'h0000_0002, 32'h8001_0000, 32'hFFFF_8001, 5'd4);
        do_load(1'b0, 3'b101, 32'h0000_0002, 32'h8001_0000, 32'h0000_8001, 5'd5);
        do_load(1'b0, 3'b010, 32'h0000_0004, 32'h1234_5678, 32'h1234_5678, 5'd6);
        do_load(1'b0, 3'b011, 32'h0000_0008, 32'h8765_4321, 32'h8765_4321, 5'd7);
        do_load(1'b0, 3'b111, 32'h0000_000C, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 5'd0);
        do_load(1'b1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 32'hCAFE_F00D, 5'd8);
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sd,
                            input logic [3:0] be_exp, input logic [31:0] wd_exp);
        set_op(1'b0, 1'b1, f3, addr, sd, 5'd4, 1'b1);
        @(negedge clk);
        total++;
        if (dmem_wen !== 1'b1 || dmem_ren !== 1'b0 || dmem_be !== be_exp || dmem_wdata !== wd_exp ||
            dmem_addr !== addr[31:2]) begin
            bad++;
            $display("[TB] FAIL store_issue got wen=%b ren=%b be=%b wdata=%h addr=%h want 1 0 %b %h %h",
                     dmem_wen, dmem_ren, dmem_be, dmem_wdata, dmem_addr, be_exp, wd_exp, addr[31:2]);
        end
        tick();
        idle_in();
        @(negedge clk);
        total++;
        if (wb_valid !== 1'b0 || dmem_wen !== 1'b0) begin
            bad++;
            $display("[TB] FAIL store_no_wb got wb_valid=%b wen=%b want 0 0", wb_valid, dmem_wen);
        end
        tick();
    endtask

    task automatic test_store();
        do_store(3'b001, 32'h0000_0006, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
        do_store(3'b001, 32'h0000_0000, 32'hFFFF_1234, 4'b0011, 32'h1234_1234);
        do_store(3'b000, 32'h0000_0001, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5);
        do_store(3'b000, 32'h0000_0003, 32'h0000_0012, 4'b1000, 32'h1212_1212);
        do_store(3'b010, 32'h0000_0008, 32'h1234_5678, 4'b1111, 32'h1234_5678);
    endtask

    task automatic test_backpressure();
        wb_ready = 1'b0;
        set_op(1'b0, 1'b0, 3'b000, 32'h0000_CAFE, 32'd0, 5'd7, 1'b1);
        @(negedge clk);
        total++;
        if (ex_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bp_first_ready got=%b want=1", ex_ready);
        end
        sb_q.push_back({5'd7, 1'b1, 32'h0000_CAFE, 1'b0, 1'b1});
        tick();
        set_op(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'd0, 5'd9, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (wb_valid !== 1'b1 || wb_data !== 32'h0000_CAFE || wb_rd !== 5'd7 || wb_we !== 1'b1 ||
                ex_ready !== 1'b0 || dmem_ren !== 1'b0 || dmem_wen !== 1'b0) begin
                bad++;
                $display("[TB] FAIL bp_stall%0d got valid=%b data=%h rd=%0d we=%b ready=%b want 1 0000cafe 7 1 0",
                         i, wb_valid, wb_data, wb_rd, wb_we, ex_ready);
            end
            tick();
        end
        wb_ready = 1'b1;
        @(negedge clk);
        total++;
        if (ex_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bp_release_ready got=%b want=1", ex_ready);
        end
        sb_q.push_back({5'd9, 1'b1, 32'h0000_1234, 1'b0, 1'b1});
        tick();
        idle_in();
        @(negedge clk);
        total++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h0000_1234 || wb_rd !== 5'd9) begin
            bad++;
            $display("[TB] FAIL bp_next got valid=%b data=%h rd=%0d want 1 00001234 9", wb_valid, wb_data, wb_rd);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            set_op(1'b0, 1'b0, 3'b000, 32'h0000_0100 + i, 32'd0, 5'd10 + 5'(i), 1'b1);
            @(negedge clk);
            total++;
            if (ex_ready !== 1'b1) begin
                bad++;
                $display("[TB] FAIL b2b_ready%0d got=%b want=1", i, ex_ready);
            end
            sb_q.push_back({5'd10 + 5'(i), 1'b1, 32'h0000_0100 + i, 1'b0, 1'b1});
            tick();
        end
        idle_in();
        @(negedge clk);
        total++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h0000_0102) begin
            bad++;
            $display("[TB] FAIL b2b_last got valid=%b data=%h want 1 00000102", wb_valid, wb_data);
        end
        tick();
    endtask

    task automatic test_reset_mid_load();
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'd0, 5'd6, 1'b1);
        dmem_rdata = 32'hAAAA_5555;
        @(negedge clk);
        total++;
        if (dmem_ren !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rml_issue got ren=%b want=1", dmem_ren);
        end
        tick();
        idle_in();
        rst = 1'b1;
        tick();
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'd0, 5'd6, 1'b1);
        @(negedge clk);
        total++;
        if (wb_valid !== 1'b0 || ex_ready !== 1'b0 || dmem_ren !== 1'b0 || dmem_wen !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rml_in_reset got valid=%b ready=%b ren=%b wen=%b want 0 0 0 0",
                     wb_valid, ex_ready, dmem_ren, dmem_wen);
        end
        tick();
        idle_in();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (wb_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL rml_after%0d got wb_valid=%b want=0", i, wb_valid);
            end
            tick();
        end
    endtask

`ifdef MISALIGN_TRAP_EN
    task automatic test_misalign();
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_0002, 32'd0, 5'd12, 1'b1);
        @(negedge clk);
        total++;
        if (ex_ready !== 1'b1 || dmem_ren !== 1'b0 || dmem_wen !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mis_lw_issue got ready=%b ren=%b wen=%b want 1 0 0", ex_ready, dmem_ren, dmem_wen);
        end
        sb_q.push_back({5'd12, 1'b0, 32'd0, 1'b1, 1'b0});
        tick();
        idle_in();
        @(negedge clk);
        total++;
        if (wb_valid !== 1'b1 || misalign !== 1'b1 || wb_we !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mis_lw_wb got valid=%b misalign=%b we=%b want 1 1 0", wb_valid, misalign, wb_we);
        end
        tick();
        set_op(1'b0, 1'b1, 3'b001, 32'h0000_0001, 32'h0000_BEEF, 5'd13, 1'b1);
        @(negedge clk);
        total++;
        if (dmem_wen !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mis_sh_issue got wen=%b want=0", dmem_wen);
        end
        sb_q.push_back({5'd13, 1'b0, 32'd0, 1'b1, 1'b0});
        tick();
        idle_in();
        @(negedge clk);
        tick();
        do_alu(32'h0000_0055, 5'd14, 1'b1);
        total++;
        if (misalign !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mis_clear got=%b want=0", misalign);
        end
    endtask
`else
    task automatic test_unaligned_ignored();
        do_load(1'b0, 3'b010, 32'h0000_0002, 32'h1122_3344, 32'h1122_3344, 5'd15);
        do_load(1'b0, 3'b001, 32'h0000_0003, 32'hABCD_0000, 32'hFFFF_ABCD, 5'd16);
        do_store(3'b010, 32'h0000_000A, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);
        do_store(3'b001, 32'h0000_0007, 32'h0000_7777, 4'b1100, 32'h7777_7777);
    endtask
`endif

    initial begin
        rst = 1'b1;
        wb_ready = 1'b1;
        dmem_rdata = 32'd0;
        ex_funct3 = 3'd0; ex_result = 32'd0; ex_store_data = 32'd0; ex_rd = 5'd0; ex_rd_we = 1'b0;
        idle_in();
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_load();
`ifdef MISALIGN_TRAP_EN
        test_misalign();
`else
        test_unaligned_ignored();
`endif
        repeat (3) tick();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL sb_drained got pending=%0d want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1, rising-edge clock; rst in 1, reset.
REQ-002 SHALL use one clock; reset is synchronous and active-high (clk, rst).
REQ-003 SHALL have upstream ports:
- ex_valid in 1, execute result offered.
- ex_ready out 1, stage accepts.
- ex_load in 1, load op.
- ex_store in 1, store op.
- ex_funct3 in 3, access size/sign.
- ex_result in 32, ALU result or effective address.
- ex_store_data in 32, store data.
- ex_rd in 5, destination register.
- ex_rd_we in 1, op writes rd.
REQ-004 SHALL have data-memory ports:
- dmem_addr out 30, word address = ex_result[31:2].
- dmem_wdata out 32.
- dmem_be out 4, byte enables.
- dmem_wen out 1.
- dmem_ren out 1.
- dmem_rdata in 32, valid the cycle after dmem_ren.
REQ-005 SHALL have writeback ports:
- wb_valid out 1.
- wb_ready in 1.
- wb_rd out 5.
- wb_we out 1.
- wb_data out 32.
- misalign out 1, present only with MISALIGN_TRAP_EN.

Function
REQ-006 SHALL implement states IDLE and LOAD_WAIT.
REQ-007 SHALL drive ex_ready = (state==IDLE) && (!wb_valid || wb_ready).
REQ-008 SHALL accept an op on a rising edge where ex_valid && ex_ready.
REQ-009 SHALL, for an accepted non-memory op, register wb_valid=1, wb_data=ex_result, wb_rd=ex_rd, wb_we=ex_rd_we && (ex_rd!=0), giving 1-cycle latency.
REQ-010 SHALL, for an accepted store, drive dmem_wen=1 combinationally in the accept cycle and produce no wb entry.
REQ-011 SHALL encode stores as:
- SB (000): be = 0001<<addr[1:0], wdata = byte replicated 4x.
- SH (001): be = 0011<<{addr[1],0}, wdata = half replicated 2x.
- SW (010): be = 1111.
REQ-012 SHALL, for an accepted load, drive dmem_ren=1 combinationally in the accept cycle, then move to LOAD_WAIT.
REQ-013 SHALL, in LOAD_WAIT, format dmem_rdata into wb_data, set wb_valid=1, and return to IDLE on the next edge; load latency is 2 cycles.
REQ-014 SHALL format loads as:
- LB (000) / LBU (100): byte at addr[1:0], sign-/zero-extended.
- LH (001) / LHU (101): half at addr[1], sign-/zero-extended.
- LW (010): full word.
- Reserved codes 011/110/111: treated as LW.
REQ-015 SHALL hold all wb_* outputs stable while wb_valid && !wb_ready.
REQ-016 SHALL clear wb_valid on a wb_ready edge unless a new result is loaded on that same edge; simultaneous drain and accept yields back-to-back results.
REQ-017 SHALL force wb_we=0 whenever wb_rd==0.
REQ-018 SHALL treat ex_load && ex_store both high as a load.
REQ-019 SHALL hold dmem_wen=dmem_ren=0 whenever no op is accepted.

Reset
REQ-020 SHALL, on rst high at an edge, set state=IDLE, wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, misalign=0.
REQ-021 SHALL discard a load in LOAD_WAIT when reset hits; no wb entry is produced.
REQ-022 SHALL hold ex_ready=0 and dmem_wen=dmem_ren=0 during reset cycles.

Configuration
REQ-023 SHALL support macro MISALIGN_TRAP_EN:
- Defined: a half access with addr[0]=1 or a word access with addr[1:0]!=0 is not issued to dmem. The stage produces a wb entry in 1 cycle with wb_we=0 and misalign=1; misalign clears on the next accepted op.
- Undefined: low address bits beyond the access size are ignored (LW uses offset 0, LH ignores addr[0]), and the misalign port is absent.

Verification
REQ-024 SHALL cover the ALU pass-through: ex_result=0x0000_0010, ex_rd=5, ex_rd_we=1 -> wb_valid next cycle, wb_data=0x10, wb_rd=5, wb_we=1.
REQ-025 SHALL cover LB sign extension: addr=0x0000_0003, dmem_rdata=0x80_11_22_33 -> wb_data=0xFFFF_FF80 two cycles after accept; LBU -> 0x0000_0080.
REQ-026 SHALL cover SH: addr=0x0000_0006, data=0x0000_BEEF -> dmem_be=1100, dmem_wdata=0xBEEF_BEEF, dmem_addr=1, no wb_valid.
REQ-027 SHALL cover backpressure: hold wb_ready=0 for 3 cycles after a result -> wb outputs stable, ex_ready=0; release -> next op accepted on the same edge.
REQ-028 SHALL cover reset mid-load: rst asserted in LOAD_WAIT -> state IDLE, wb_valid=0 and stays 0.
REQ-029 SHALL cover misalignment, MISALIGN_TRAP_EN defined: LW at 0x0000_0002 -> dmem_ren=0, misalign=1, wb_we=0.
